// File: rtl/dac_sweep_sequencer.sv
// dac_sweep_sequencer: shifts RANGE_BINS clutter samples per trigger out to the serial DAC as 32-bit SPI frames
module dac_sweep_sequencer #(
  parameter int DATA_W = 12,
  parameter int CLK_DIV = 2,
  parameter int RANGE_BINS = 256,
  parameter int BIN_W = 9,
  parameter logic [3:0] DAC_CMD = 4'b0011,
  parameter logic [3:0] DAC_ADDR = 4'b0000,
  parameter logic [DATA_W-1:0] ZERO_LEVEL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              smp_valid,
  output logic              smp_ready,
  output logic              DACin,
  output logic              DACclk,
  output logic              DAC_CS,
  output logic              DAC_CLR,
  output logic              busy,
  output logic [BIN_W-1:0]  bin_cnt,
  output logic              underrun
);
  localparam int FRAME_W = DATA_W + 20;
  localparam int CNT_W = $clog2(FRAME_W);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
  state_t state;
  logic trig_d;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [FRAME_W-1:0] sr, frame;
  logic [DATA_W-1:0] smp;
  logic div_end;
  always_comb begin
    smp = smp_valid ? smp_data : ZERO_LEVEL;
    frame = {8'h00, DAC_CMD, DAC_ADDR, smp, 4'h0};
    div_end = div_cnt == DIV_W'(CLK_DIV - 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      trig_d <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sr <= '0;
      smp_ready <= 1'b0;
      DACin <= 1'b0;
      DACclk <= 1'b0;
      DAC_CS <= 1'b1;
      DAC_CLR <= 1'b0;
      busy <= 1'b0;
      bin_cnt <= '0;
      underrun <= 1'b0;
    end else begin
      trig_d <= trig;
      DAC_CLR <= 1'b1;
      smp_ready <= 1'b0;
      case (state)
        IDLE: if (trig && !trig_d) begin
          state <= LOAD;
          bin_cnt <= '0;
          underrun <= 1'b0;
          busy <= 1'b1;
        end
        LOAD: begin
          smp_ready <= smp_valid;
          underrun <= underrun | ~smp_valid;
          DAC_CS <= 1'b0;
          DACin <= frame[FRAME_W-1];
          sr <= frame << 1;
          DACclk <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= CNT_W'(FRAME_W - 1);
          state <= SHIFT;
        end
        SHIFT: begin
          div_cnt <= div_end ? '0 : div_cnt + 1'b1;
          // new bit is presented on the falling edge so the DAC samples it mid-bit on the rise
          if (div_end && !DACclk) DACclk <= 1'b1;
          else if (div_end) begin
            DACclk <= 1'b0;
            if (bit_cnt == '0) begin
              DAC_CS <= 1'b1;
              DACin <= 1'b0;
              state <= GAP;
            end else begin
              DACin <= sr[FRAME_W-1];
              sr <= sr << 1;
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        GAP: begin
          div_cnt <= div_end ? '0 : div_cnt + 1'b1;
          if (div_end && bin_cnt == BIN_W'(RANGE_BINS - 1)) begin
            busy <= 1'b0;
            state <= IDLE;
          end else if (div_end) begin
            bin_cnt <= bin_cnt + 1'b1;
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dac_sweep_sequencer.sv
// tb_dac_sweep_sequencer: directed sweeps with a frame scoreboard fed by the sample generator model
module tb_dac_sweep_sequencer;
  localparam int RB = 16;
  localparam int FL = 131;
  logic clk = 1'b0, rst = 1'b1, trig = 1'b0;
  logic [11:0] smp_data = 12'hA5C;
  logic smp_valid = 1'b1;
  logic smp_ready, DACin, DACclk, DAC_CS, DAC_CLR, busy, underrun;
  logic [8:0] bin_cnt;
  int n_tests = 0, n_fail = 0;
  logic [31:0] q[$];
  logic [31:0] cap = '0, first_frame = '0;
  int exp_bin = 0, n_frames = 0, nbits = 0, since_fall = -1, ready_cnt = 0, busy_cyc = 0;
  logic drop3 = 1'b0, in_frame = 1'b0, got_first = 1'b0;
  logic prev_cs = 1'b1, prev_dclk = 1'b0, prev_ready = 1'b0;

  dac_sweep_sequencer #(.RANGE_BINS(RB)) dut (
    .clk(clk), .rst(rst), .trig(trig), .smp_data(smp_data), .smp_valid(smp_valid),
    .smp_ready(smp_ready), .DACin(DACin), .DACclk(DACclk), .DAC_CS(DAC_CS),
    .DAC_CLR(DAC_CLR), .busy(busy), .bin_cnt(bin_cnt), .underrun(underrun)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] fr(input logic [11:0] s);
    return {8'h00, 4'h3, 4'h0, s, 4'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // generator model + scoreboard + SPI capture, all on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      in_frame = 1'b0;
      nbits = 0;
      since_fall = -1;
      prev_cs = 1'b1;
      prev_dclk = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (since_fall >= 0) since_fall++;
      if (busy) busy_cyc++;
      if (smp_ready) begin
        chk("ready_1cyc", 32'(prev_ready), 0);
        chk("ready_in_sweep", 32'(busy), 1);
        ready_cnt++;
      end
      if (prev_cs && !DAC_CS) begin
        if (since_fall > 0) chk("frame_len", since_fall, FL);
        chk("bin_idx", 32'(bin_cnt), exp_bin);
        exp_bin++;
        q.push_back(smp_valid ? fr(smp_data) : fr(12'h000));
        chk("ready_on_load", 32'(smp_ready), 32'(smp_valid));
        if (smp_valid) smp_data++;
        in_frame = 1'b1;
        nbits = 0;
        cap = '0;
        since_fall = 0;
      end
      if (in_frame && !DAC_CS && !prev_dclk && DACclk) begin
        cap = {cap[30:0], DACin};
        nbits++;
      end
      if (in_frame && !prev_cs && DAC_CS) begin
        chk("nbits", nbits, 32);
        chk("frame", cap, q.size() > 0 ? q.pop_front() : 32'hDEADDEAD);
        if (!got_first) begin
          first_frame = cap;
          got_first = 1'b1;
        end
        n_frames++;
        in_frame = 1'b0;
      end
      smp_valid = !(drop3 && bin_cnt == 9'd3);
      prev_cs = DAC_CS;
      prev_dclk = DACclk;
      prev_ready = smp_ready;
    end
  end

  task automatic start_sweep();
    exp_bin = 0;
    n_frames = 0;
    ready_cnt = 0;
    busy_cyc = 0;
    since_fall = -1;
    trig = 1'b1;
    @(negedge clk);
    chk("trig_busy", 32'(busy), 1);
    chk("trig_cs_hi", 32'(DAC_CS), 1);
    trig = 1'b0;
    @(negedge clk);
    chk("load_cs_lo", 32'(DAC_CS), 0);
  endtask

  task automatic finish_sweep(input int readies, input logic exp_ur);
    for (int i = 0; i < RB * FL + 50 && busy; i++) @(negedge clk);
    chk("sweep_done", 32'(busy), 0);
    chk("busy_len", busy_cyc, RB * FL);
    chk("frames", n_frames, RB);
    chk("q_empty", q.size(), 0);
    chk("readies", ready_cnt, readies);
    chk("underrun_end", 32'(underrun), 32'(exp_ur));
    chk("bin_last", 32'(bin_cnt), RB - 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cs", 32'(DAC_CS), 1);
    chk("rst_dclk", 32'(DACclk), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_clr", 32'(DAC_CLR), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("clr_release", 32'(DAC_CLR), 1);
    chk("idle_cs", 32'(DAC_CS), 1);
    // plain sweep, first frame decoded against the known pattern
    start_sweep();
    finish_sweep(RB, 1'b0);
    chk("first_frame", first_frame, 32'h0030A5C0);
    // underrun on bin 3
    drop3 = 1'b1;
    @(negedge clk);
    start_sweep();
    for (int i = 0; i < 10 * FL && bin_cnt != 9'd4; i++) @(negedge clk);
    chk("reach_bin4", 32'(bin_cnt), 4);
    chk("underrun_set", 32'(underrun), 1);
    finish_sweep(RB - 1, 1'b1);
    drop3 = 1'b0;
    repeat (3) @(negedge clk);
    chk("underrun_hold", 32'(underrun), 1);
    // retrigger during the sweep must be ignored
    start_sweep();
    chk("underrun_clr", 32'(underrun), 0);
    for (int i = 0; i < 20 * FL && bin_cnt != 9'd10; i++) @(negedge clk);
    chk("reach_bin10", 32'(bin_cnt), 10);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    @(negedge clk);
    chk("retrig_bin", 32'(bin_cnt), 10);
    finish_sweep(RB, 1'b0);
    // reset in the middle of bin 5's frame
    @(negedge clk);
    start_sweep();
    for (int i = 0; i < 10 * FL && !(bin_cnt == 9'd5 && nbits == 17 && in_frame); i++) @(negedge clk);
    chk("reach_bit17", nbits, 17);
    #2 rst = 1'b1;
    #1;
    chk("async_cs", 32'(DAC_CS), 1);
    chk("async_dclk", 32'(DACclk), 0);
    chk("async_din", 32'(DACin), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_bin", 32'(bin_cnt), 0);
    chk("async_ready", 32'(smp_ready), 0);
    chk("async_clr", 32'(DAC_CLR), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("clr_again", 32'(DAC_CLR), 1);
    start_sweep();
    finish_sweep(RB, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
